// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder with a valid/ready stream interface and an optional
// lower-part-OR approximation of the low APX_BITS bits, selected per transaction.

module csel_seg #(
  parameter int SEG = 16,
  parameter int BLK = 4
) (
  input  logic [SEG-1:0] i_x,
  input  logic [SEG-1:0] i_y,
  input  logic           i_c,
  output logic [SEG-1:0] o_s,
  output logic           o_c
);
  localparam int NBLK = SEG / BLK;

  logic [NBLK:0] w_c;

  assign w_c[0] = i_c;

  generate
    for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
      if (gi == 0) begin : g_ripple
        assign {w_c[1], o_s[BLK-1:0]} = {1'b0, i_x[BLK-1:0]} + {1'b0, i_y[BLK-1:0]}
                                        + {{BLK{1'b0}}, w_c[0]};
      end else begin : g_select
        logic [BLK:0] w_r0;
        logic [BLK:0] w_r1;
        // Both carry hypotheses are ready before the incoming carry settles.
        assign w_r0 = {1'b0, i_x[gi*BLK +: BLK]} + {1'b0, i_y[gi*BLK +: BLK]};
        assign w_r1 = {1'b0, i_x[gi*BLK +: BLK]} + {1'b0, i_y[gi*BLK +: BLK]}
                      + {{BLK{1'b0}}, 1'b1};
        assign {w_c[gi+1], o_s[gi*BLK +: BLK]} = w_c[gi] ? w_r1 : w_r0;
      end
    end
  endgenerate

  assign o_c = w_c[NBLK];
endmodule

module csel_adder_pipe #(
  parameter int WIDTH    = 32,
  parameter int BLK      = 4,
  parameter int STAGES   = 2,
  parameter int APX_BITS = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  input  logic             i_apx_en,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co
);
  localparam int SEG = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic APX_ON = (APX_BITS > 0);
  // Bits replaced by a|b in approximate mode.
  localparam logic [WIDTH-1:0] OR_MASK = (APX_BITS == 0) ? '0 : (ONES >> (WIDTH - APX_BITS));
  // Operand bits zeroed in approximate mode so that only bit APX_BITS-1 generates a carry.
  localparam logic [WIDTH-1:0] ZERO_MASK = (APX_BITS <= 1) ? '0 : (ONES >> (WIDTH - APX_BITS + 1));

  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_apx;
  logic [STAGES-1:0] r_vld;

  logic [WIDTH-1:0] w_a_in   [STAGES];
  logic [WIDTH-1:0] w_b_in   [STAGES];
  logic [WIDTH-1:0] w_sum_in [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_apx_in;
  logic [STAGES-1:0] w_vld_in;

  logic [WIDTH-1:0] w_a_nx   [STAGES];
  logic [WIDTH-1:0] w_b_nx   [STAGES];
  logic [WIDTH-1:0] w_sum_nx [STAGES];
  logic [STAGES-1:0] w_c_nx;

  logic w_en;

  assign w_en       = i_out_ready | ~r_vld[STAGES-1];
  assign o_in_ready = w_en;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int BASE = gi * SEG;
      localparam logic [WIDTH-1:0] KEEP = (gi == STAGES - 1) ? '0 : (ONES << ((gi + 1) * SEG));

      logic [SEG-1:0]   w_x;
      logic [SEG-1:0]   w_y;
      logic [SEG-1:0]   w_xa;
      logic [SEG-1:0]   w_ya;
      logic [SEG-1:0]   w_raw;
      logic [SEG-1:0]   w_seg;
      logic [WIDTH-1:0] w_seg_full;
      logic             w_co;

      if (gi == 0) begin : g_first
        assign w_a_in[gi]   = i_a;
        assign w_b_in[gi]   = i_b;
        assign w_sum_in[gi] = '0;
        assign w_c_in[gi]   = i_ci & ~(i_apx_en & APX_ON);
        assign w_apx_in[gi] = i_apx_en;
        assign w_vld_in[gi] = i_in_valid;
      end else begin : g_next
        assign w_a_in[gi]   = r_a[gi-1];
        assign w_b_in[gi]   = r_b[gi-1];
        assign w_sum_in[gi] = r_sum[gi-1];
        assign w_c_in[gi]   = r_c[gi-1];
        assign w_apx_in[gi] = r_apx[gi-1];
        assign w_vld_in[gi] = r_vld[gi-1];
      end

      assign w_x  = w_a_in[gi][BASE +: SEG];
      assign w_y  = w_b_in[gi][BASE +: SEG];
      assign w_xa = w_apx_in[gi] ? (w_x & ~ZERO_MASK[BASE +: SEG]) : w_x;
      assign w_ya = w_apx_in[gi] ? (w_y & ~ZERO_MASK[BASE +: SEG]) : w_y;

      csel_seg #(
        .SEG (SEG),
        .BLK (BLK)
      ) u_seg (
        .i_x (w_xa),
        .i_y (w_ya),
        .i_c (w_c_in[gi]),
        .o_s (w_raw),
        .o_c (w_co)
      );

      assign w_seg = w_apx_in[gi]
                   ? ((w_raw & ~OR_MASK[BASE +: SEG]) | ((w_x | w_y) & OR_MASK[BASE +: SEG]))
                   : w_raw;
      assign w_seg_full   = WIDTH'(w_seg) << BASE;
      assign w_sum_nx[gi] = w_sum_in[gi] | w_seg_full;
      assign w_a_nx[gi]   = w_a_in[gi] & KEEP;
      assign w_b_nx[gi]   = w_b_in[gi] & KEEP;
      assign w_c_nx[gi]   = w_co;
    end
  endgenerate

  // Data registers load only behind a valid predecessor, so bubble operands never propagate.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
      r_c   <= '0;
      r_apx <= '0;
      r_vld <= '0;
    end else if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_vld_in[k];
        if (w_vld_in[k]) begin
          r_a[k]   <= w_a_nx[k];
          r_b[k]   <= w_b_nx[k];
          r_sum[k] <= w_sum_nx[k];
          r_c[k]   <= w_c_nx[k];
          r_apx[k] <= w_apx_in[k];
        end
      end
    end
  end

  assign o_out_valid = r_vld[STAGES-1];
  assign o_s         = r_sum[STAGES-1];
  assign o_co        = r_c[STAGES-1];
endmodule

// File: tb/tb_csel_adder_pipe.sv
// Scoreboard bench for csel_adder_pipe: directed vectors with hand-computed sums,
// checked in order by an independent output monitor.

module tb_csel_adder_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ci = 1'b0;
  logic         apx_en = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         co;

  always #5 clk = ~clk;

  csel_adder_pipe #(
    .WIDTH    (32),
    .BLK      (4),
    .STAGES   (2),
    .APX_BITS (8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .i_ci        (ci),
    .i_apx_en    (apx_en),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_s         (s),
    .o_co        (co)
  );

  typedef struct {
    logic [32:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail = 0;
  logic acc = 1'b0;
  logic stall_prev = 1'b0;
  logic [33:0] held = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Monitor: every output handshake pops one expected result; stalled outputs must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("hold_during_stall", 64'({out_valid, co, s}), 64'(held));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'(0));
        end else begin
          e = q.pop_front();
          chk(e.nm, 64'({co, s}), 64'(e.v));
          $display("[TB] result %s: s=0x%08h co=%0d", e.nm, s, co);
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_valid, co, s};
    end
  end

  task automatic drive(input logic v, input logic [31:0] ta, input logic [31:0] tb_,
                       input logic tci, input logic tapx, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = v ? ta : 'x;
    b         = v ? tb_ : 'x;
    ci        = v ? tci : 1'bx;
    apx_en    = v ? tapx : 1'bx;
    out_ready = ordy;
    @(negedge clk);
    acc = v && in_ready;
  endtask

  task automatic push(input logic [32:0] expv, input string nm);
    exp_t t;
    t.v  = expv;
    t.nm = nm;
    q.push_back(t);
  endtask

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic tci,
                       input logic tapx, input logic [32:0] expv, input string nm);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 10 && !done; t++) begin
      drive(1'b1, ta, tb_, tci, tapx, 1'b1);
      if (acc) begin
        push(expv, nm);
        done = 1'b1;
      end
    end
    chk({nm, "_accepted"}, 64'(done), 64'(1));
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && q.size() > 0; t++)
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("drain_queue_empty", 64'(q.size()), 64'(0));
  endtask

  logic [31:0] sa [4] = '{32'hFFFF0000, 32'h0000FFFF, 32'h00008000, 32'h55555555};
  logic [31:0] sb [4] = '{32'h00010000, 32'h00000001, 32'h00008000, 32'hAAAAAAAA};
  logic        sc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [32:0] sx [4] = '{33'h1_00000000, 33'h0_00010000, 33'h0_00010001, 33'h0_FFFFFFFF};

  logic [31:0] ba [6] = '{32'h12345678, 32'hDEADBEEF, 32'h80000000, 32'h0F0F0F0F, 32'h000000FF, 32'h00001234};
  logic [31:0] bb [6] = '{32'h11111111, 32'h21524111, 32'h80000000, 32'hF0F0F0F0, 32'h000000FF, 32'h00004321};
  logic        bc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        bx [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [32:0] be [6] = '{33'h0_23456789, 33'h1_00000000, 33'h1_00000001, 33'h1_00000000, 33'h0_000001FF, 33'h0_00005555};

  task automatic stream(input logic [11:0] pat, input string nm);
    int j;
    j = 0;
    for (int i = 0; i < 12; i++) begin
      drive(pat[i], sa[j], sb[j], sc[j], 1'b0, 1'b1);
      if (acc) begin
        push(sx[j], $sformatf("%s_v%0d", nm, j));
        j = (j + 1) % 4;
      end
      if (i >= 2)
        chk($sformatf("%s_valid_c%0d", nm, i), 64'(out_valid), 64'(pat[i-2]));
    end
    drain();
  endtask

  initial begin
    int idx;
    logic ordy;

    // Reset state
    #2;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_s", 64'(s), 64'(0));
    chk("reset_co", 64'(co), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Latency and exact wrap
    drive(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
    if (acc) push(33'h1_00000000, "exact_wrap");
    chk("wrap_accepted", 64'(acc), 64'(1));
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("latency_c1_not_valid", 64'(out_valid), 64'(0));
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("latency_c2_valid", 64'(out_valid), 64'(1));
    drain();

    // Carry-in chain and approximate mode, back to back
    issue(32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 33'h0_80000000, "cin_chain");
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 33'h1_FFFFFFFF, "all_ones_cin");
    issue(32'h000000FF, 32'h00000001, 1'b0, 1'b1, 33'h0_000000FF, "apx_or_low");
    issue(32'h000000FF, 32'h00000001, 1'b1, 1'b1, 33'h0_000000FF, "apx_ignores_ci");
    issue(32'h00000080, 32'h00000080, 1'b1, 1'b1, 33'h0_00000180, "apx_carry_b7");
    issue(32'h00000080, 32'h00000080, 1'b1, 1'b0, 33'h0_00000101, "exact_same_ops");
    drain();

    // Backpressure: out_ready low for cycles 3..5 while the stream continues
    idx = 0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      ordy = !(c >= 3 && c <= 5);
      drive(1'b1, ba[idx], bb[idx], bc[idx], bx[idx], ordy);
      if (acc) begin
        push(be[idx], $sformatf("bp_v%0d", idx));
        idx++;
      end
      if (!ordy) begin
        chk($sformatf("stall_in_ready_c%0d", c), 64'(in_ready), 64'(0));
        chk($sformatf("stall_out_valid_c%0d", c), 64'(out_valid), 64'(1));
      end
    end
    chk("bp_all_accepted", 64'(idx), 64'(6));
    drain();

    // Bubbles and full throughput
    stream(12'b0000_0101_0101, "alt");
    stream(12'b0000_0011_1111, "cont");

    // Asynchronous reset with two transactions in flight
    issue(32'h11111111, 32'h22222222, 1'b0, 1'b0, 33'h0_33333333, "pre_rst_a");
    issue(32'h44444444, 32'h44444444, 1'b0, 1'b0, 33'h0_88888888, "pre_rst_b");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 'x;
    b = 'x;
    #2;
    chk("pre_reset_out_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_s", 64'(s), 64'(0));
    chk("async_rst_co", 64'(co), 64'(0));
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("no_stale_c%0d", i), 64'(out_valid), 64'(0));
    end
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 33'h1_00000000, "post_rst_wrap");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/csel_adder_pipe.md
Name: csel_adder_pipe

Overview:
- Parametrised, pipelined carry-select adder; next generation of the fixed 32-bit 4-bit-block carry-select adder.
- Generalised in width, block size and pipeline depth.
- Adds a valid/ready stream interface and a runtime-selectable approximate lower-part-OR mode (LOA) for error/energy studies.
- Sits in the datapath as the final accumulate adder of the multiplier wrappers.

Parameters:
- WIDTH, 32: operand/sum width. Legal when WIDTH % (BLK*STAGES) == 0.
- BLK, 4: carry-select block width.
  - Block 0 of each stage is a plain ripple block.
  - Every other block computes cin=0 and cin=1 sums and muxes on the incoming carry.
- STAGES, 2: number of register stages. Also the latency. Range 1..WIDTH/BLK.
- APX_BITS, 8: low bits approximated when apx_en=1. Range 0..WIDTH-1. 0 means the mode has no effect.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operands valid.
- in_ready, output, 1: block accepts operands this cycle.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- ci, input, 1: carry in.
- apx_en, input, 1: 1 = approximate mode for this transaction.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- s, output, WIDTH: sum.
- co, output, 1: carry out.

Behaviour:
- Reset (rst_n low, async): all stage valid bits=0, out_valid=0, s=0, co=0, all pipeline data regs=0. Takes effect immediately and discards in-flight transactions. First accept is possible on the first rising edge after release.
- Segmentation:
  - WIDTH is split into STAGES equal segments, LSB segment first.
  - Stage k adds segment k using the registered carry from stage k-1 (stage 0 uses ci).
  - Stage k registers: the accumulated low sum bits, the segment carry, the unconsumed upper operand bits, apx_en, and a valid bit.
- Latency: a transaction accepted on edge n appears on s/co with out_valid=1 after edge n+STAGES-1 when there is no stall, i.e. STAGES register stages.
- Handshake:
  - Global enable en = out_ready | ~out_valid.
  - in_ready = en, combinational.
  - Accept occurs when in_valid & in_ready.
  - When en=1, every stage shifts by one. A stage whose predecessor holds no valid data loads a bubble (valid=0).
  - When en=0, all stages hold. s, co and out_valid are stable while out_valid & ~out_ready.
  - Results are delivered in order, with no loss and no duplication.
  - Simultaneous output consume and input accept in the same cycle gives full throughput (1 per cycle).
- Exact mode (apx_en=0): {co,s} = a + b + ci, modulo 2^(WIDTH+1).
- Approximate mode (apx_en=1, APX_BITS>0):
  - s[APX_BITS-1:0] = a|b on those bits.
  - The carry into bit APX_BITS is a[APX_BITS-1] & b[APX_BITS-1]; ci is ignored.
  - Upper bits are added exactly with that carry.
- apx_en is sampled with the operands and travels with the transaction. Mode changes between back-to-back transactions take effect per transaction.
- Boundaries:
  - Full carry propagation across all stages must be exact, e.g. all-ones + 1.
  - in_valid=0 creates bubbles that are squeezed out only as en allows. out_valid is never asserted for a bubble.
  - X on a/b while in_valid=0 must not reach s.

Test Plan (WIDTH=32, BLK=4, STAGES=2, APX_BITS=8):
- Exact wrap: a=0xFFFFFFFF, b=0x00000001, ci=0, apx_en=0 -> 2 cycles later s=0x00000000, co=1, out_valid=1.
- Carry-in chain: a=0x7FFFFFFF, b=0, ci=1 -> s=0x80000000, co=0. Then a=b=0xFFFFFFFF, ci=1 -> s=0xFFFFFFFF, co=1.
- Approx mode:
  - a=0x000000FF, b=0x00000001, apx_en=1 -> s=0x000000FF, co=0 (exact would be 0x100).
  - a=b=0x00000080, ci=1, apx_en=1 -> s=0x00000180.
  - Same operands with apx_en=0 -> s=0x00000101.
- Backpressure: stream 6 random vectors with in_valid=1; hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, s/co held, all 6 results match a golden model, in order.
- Throughput/bubbles: alternate in_valid 1/0 with out_ready=1 -> out_valid pattern equals the input pattern delayed 2 cycles. With continuous in_valid, one result per cycle.
- Reset mid-operation: pull rst_n low asynchronously between edges with 2 transactions in flight -> out_valid=0, s=0, co=0 immediately; after release, no stale result ever appears.
